// File: rtl/rs_pkg.sv
// rs_pkg -- shared types and GF(2^m) helpers for the RS(N, N-2) stream decoder.
//   rs_state_t : decoder FSM states (LOAD, SOLVE, EMIT)
//   rs_n/rs_k  : codeword / data length for a given symbol width m
//   gf_mul     : GF(2^m) multiply modulo a primitive polynomial (m <= 8)
package rs_pkg;

   typedef enum logic [1:0] {LOAD, SOLVE, EMIT} rs_state_t;

   localparam int GF_MAX_W = 8;

   function automatic int rs_n(input int m);
      return (1 << m) - 1;
   endfunction

   function automatic int rs_k(input int m);
      return rs_n(m) - 2;
   endfunction

   // Shift-and-add multiply, MSB of b first; reduces whenever bit m is set.
   // Operands are assumed to be already reduced (< 2^m).
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                         input int m, input logic [8:0] poly);
      logic [8:0] p;
      p = '0;
      for (int i = GF_MAX_W - 1; i >= 0; i--) begin
         if (i < m) begin
            p = p << 1;
            if (p[m]) p = p ^ poly;
            if (b[i]) p = p ^ {1'b0, a};
         end
      end
      return p[7:0];
   endfunction

endpackage

// File: rtl/rs_stream_decoder_gf_log.sv
// rs_gf_log -- log / antilog lookup for GF(2^SYMBOL_WIDTH) with alpha = x.
//   log_a, log_b   : field elements to take the log of (log of 0 reads as 0)
//   log_a_val/_b_val: exponents 0..N-1
//   exp_idx        : exponent; exp_val = alpha^exp_idx
module rs_gf_log
   import rs_pkg::*;
#(
   parameter int                    SYMBOL_WIDTH = 3,
   parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011
) (
   input  logic [SYMBOL_WIDTH-1:0] log_a,
   input  logic [SYMBOL_WIDTH-1:0] log_b,
   output logic [SYMBOL_WIDTH-1:0] log_a_val,
   output logic [SYMBOL_WIDTH-1:0] log_b_val,
   input  logic [SYMBOL_WIDTH-1:0] exp_idx,
   output logic [SYMBOL_WIDTH-1:0] exp_val
);

   localparam int         W     = SYMBOL_WIDTH;
   localparam int         N     = rs_n(W);
   localparam int         TBL   = 1 << W;
   localparam logic [8:0] POLY9 = 9'(PRIM_POLY);

   // Full 2^W entries so every W-bit index is in range; entry N wraps to 1.
   logic [W-1:0] exp_tab [TBL];

   always_comb begin
      logic [W-1:0] x;
      x = W'(1);
      for (int i = 0; i < TBL; i++) begin
         exp_tab[i] = x;
         x = W'(gf_mul(8'(x), 8'd2, W, POLY9));
      end
   end

   // Inverse lookup by search over the antilog table.
   always_comb begin
      log_a_val = '0;
      log_b_val = '0;
      for (int i = 0; i < N; i++) begin
         if (exp_tab[i] == log_a) log_a_val = W'(i);
         if (exp_tab[i] == log_b) log_b_val = W'(i);
      end
   end

   assign exp_val = exp_tab[exp_idx];

endmodule

// File: rtl/rs_stream_decoder.sv
// rs_stream_decoder -- streaming single-symbol-error RS(N, N-2) decoder.
// Frames of N symbols arrive highest position first; syndromes are built by
// Horner while loading, a 3-cycle SOLVE locates/values the error, and EMIT
// replays the buffered frame with the correction applied.
//   clk, reset        : clock, synchronous active-low reset
//   in_valid/in_ready/in_symbol     : input symbol stream
//   out_valid/out_ready/out_symbol  : corrected symbol stream
//   out_last          : position 0 of the frame
//   out_corrected     : one error was corrected (held for the frame)
//   out_uncorrectable : frame passed through unmodified (held for the frame)
// Optional macro RS_DEC_ERR_COUNT_EN adds saturating 16-bit corr_count and
// uncorr_count outputs, bumped once per frame on entry to EMIT.
module rs_stream_decoder
   import rs_pkg::*;
#(
   parameter int                    SYMBOL_WIDTH = 3,
   parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SYMBOL_WIDTH-1:0] in_symbol,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SYMBOL_WIDTH-1:0] out_symbol,
   output logic                    out_last,
   output logic                    out_corrected,
   output logic                    out_uncorrectable
`ifdef RS_DEC_ERR_COUNT_EN
  ,output logic [15:0]             corr_count,
   output logic [15:0]             uncorr_count
`endif
);

   localparam int         W       = SYMBOL_WIDTH;
   localparam int         N       = rs_n(W);
   localparam int         K       = rs_k(W);
   // Highest symbol position: K data symbols plus two parity symbols, minus one.
   localparam logic [W-1:0] TOP_POS = W'(K + 1);
   localparam logic [8:0] POLY9   = 9'(PRIM_POLY);

   rs_state_t    state;
   logic [W-1:0] pos;        // load write position, then emit read position
   logic [1:0]   solve_cnt;
   logic [W-1:0] s1, s2;
   logic [W-1:0] log_s1, log_s2;
   logic [W-1:0] j_pos, y_exp, y1;
   logic [W-1:0] sym_buf [N];

   logic [W-1:0] l1, l2, exp_val;

   rs_gf_log #(.SYMBOL_WIDTH(SYMBOL_WIDTH), .PRIM_POLY(PRIM_POLY)) u_log (
      .log_a     (s1),
      .log_b     (s2),
      .log_a_val (l1),
      .log_b_val (l2),
      .exp_idx   (y_exp),
      .exp_val   (exp_val)
   );

   // Exponent arithmetic modulo N; inputs are always in 0..N-1.
   function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[W]) d = d + (W+1)'(N);
      return d[W-1:0];
   endfunction

   function automatic logic [W-1:0] mod_dbl(input logic [W-1:0] a);
      logic [W:0] d;
      d = {a, 1'b0};
      if (d >= (W+1)'(N)) d = d - (W+1)'(N);
      return d[W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (state == LOAD && in_valid) sym_buf[pos] <= in_symbol;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= LOAD;
         pos               <= TOP_POS;
         solve_cnt         <= '0;
         s1                <= '0;
         s2                <= '0;
         log_s1            <= '0;
         log_s2            <= '0;
         j_pos             <= '0;
         y_exp             <= '0;
         y1                <= '0;
         in_ready          <= 1'b1;
         out_valid         <= 1'b0;
         out_last          <= 1'b0;
         out_corrected     <= 1'b0;
         out_uncorrectable <= 1'b0;
`ifdef RS_DEC_ERR_COUNT_EN
         corr_count        <= '0;
         uncorr_count      <= '0;
`endif
      end else begin
         case (state)
            LOAD: if (in_valid) begin
               s1 <= W'(gf_mul(8'(s1), 8'd2, W, POLY9)) ^ in_symbol;
               s2 <= W'(gf_mul(gf_mul(8'(s2), 8'd2, W, POLY9), 8'd2, W, POLY9)) ^ in_symbol;
               if (pos == '0) begin
                  state     <= SOLVE;
                  in_ready  <= 1'b0;
                  pos       <= TOP_POS;
                  solve_cnt <= '0;
               end else begin
                  pos <= pos - 1'b1;
               end
            end
            SOLVE: begin
               solve_cnt <= solve_cnt + 1'b1;
               case (solve_cnt)
                  2'd0: begin
                     log_s1 <= l1;
                     log_s2 <= l2;
                  end
                  2'd1: begin
                     // X1 = S2/S1 -> j = log S2 - log S1; Y1 = S1^2/S2.
                     j_pos <= mod_sub(log_s2, log_s1);
                     y_exp <= mod_sub(mod_dbl(log_s1), log_s2);
                  end
                  default: begin
                     y1                <= exp_val;
                     out_corrected     <= (s1 != '0) && (s2 != '0);
                     out_uncorrectable <= (s1 == '0) != (s2 == '0);
                     state             <= EMIT;
                     out_valid         <= 1'b1;
                     out_last          <= 1'b0;
`ifdef RS_DEC_ERR_COUNT_EN
                     if ((s1 != '0) && (s2 != '0) && (corr_count != 16'hFFFF))
                        corr_count <= corr_count + 16'd1;
                     if (((s1 == '0) != (s2 == '0)) && (uncorr_count != 16'hFFFF))
                        uncorr_count <= uncorr_count + 16'd1;
`endif
                  end
               endcase
            end
            EMIT: if (out_ready) begin
               if (pos == '0) begin
                  state             <= LOAD;
                  pos               <= TOP_POS;
                  solve_cnt         <= '0;
                  s1                <= '0;
                  s2                <= '0;
                  in_ready          <= 1'b1;
                  out_valid         <= 1'b0;
                  out_last          <= 1'b0;
                  out_corrected     <= 1'b0;
                  out_uncorrectable <= 1'b0;
               end else begin
                  pos      <= pos - 1'b1;
                  out_last <= (pos == W'(1));
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // pos only moves on a handshake, so the symbol holds through a stall.
   assign out_symbol = sym_buf[pos] ^ ((out_corrected && (pos == j_pos)) ? y1 : '0);

endmodule

// File: doc/rs_stream_decoder.md
RS_STREAM_DECODER -- requirements
Module: rs_stream_decoder

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 3, meaning symbol width m in bits.
REQ-002 SHALL have parameter PRIM_POLY, default 4'b1011, meaning GF(2^m) primitive polynomial including the x^m term.
REQ-003 SHALL derive localparam N = 2^SYMBOL_WIDTH - 1 (codeword length) and K = N - 2 (data symbols).
REQ-004 SHALL have the port list:
  clk  in  1  clock; all logic on the rising edge.
  reset  in  1  synchronous, active-low reset.
  in_valid  in  1  input symbol valid.
  in_ready  out  1  decoder accepts an input symbol.
  in_symbol  in  SYMBOL_WIDTH  received symbol; highest position r[N-1] first.
  out_valid  out  1  corrected symbol valid.
  out_ready  in  1  downstream accepts a symbol.
  out_symbol  out  SYMBOL_WIDTH  corrected symbol, same order as input.
  out_last  out  1  marks position 0 (last symbol of the frame).
  out_corrected  out  1  frame had one error that was corrected; held for the whole frame.
  out_uncorrectable  out  1  frame is uncorrectable and is passed through unchanged; held for the whole frame.

Function
REQ-005 SHALL implement a FSM with states LOAD, SOLVE and EMIT; LOAD is the reset state.
REQ-006 In LOAD: in_ready=1; each in_valid&in_ready beat stores the symbol in an N-entry buffer at position N-1-cnt.
REQ-007 Each LOAD beat: S1 <= S1*alpha ^ in_symbol; S2 <= S2*alpha^2 ^ in_symbol (Horner).
REQ-008 The N-th accepted beat SHALL move LOAD->SOLVE; there is no input framing signal.
REQ-009 SOLVE SHALL last exactly 3 cycles with in_ready=0, out_valid=0, then move to EMIT.
REQ-010 SOLVE with S1=0 and S2=0: no error; out_corrected=0, out_uncorrectable=0.
REQ-011 SOLVE with S1!=0 and S2!=0: X1=S2/S1=alpha^j; error position j=log(X1), always in 0..N-1; Y1=S1^2/S2; out_corrected=1.
REQ-012 SOLVE with exactly one of S1, S2 zero: out_uncorrectable=1; no symbol is modified.
REQ-013 In EMIT: out_valid=1; out_symbol = buf[p] ^ (p==j && corrected ? Y1 : 0), for p from N-1 down to 0; p advances only on out_valid&out_ready.
REQ-014 out_last SHALL be 1 only when p=0. The out_last handshake SHALL clear S1, S2, counters and flags and return to LOAD.
REQ-015 out_symbol SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 in_ready SHALL be 0 in SOLVE and EMIT; input and output never overlap.
REQ-017 All GF arithmetic SHALL be modulo PRIM_POLY; inputs and results are SYMBOL_WIDTH wide; division by 0 SHALL NOT occur (guarded by REQ-010/012).

Reset
REQ-018 When reset=0 at a clock edge: state=LOAD, counters=0, S1=S2=0, in_ready=1 on the next cycle, out_valid=0, out_last=0, out_corrected=0, out_uncorrectable=0.
REQ-019 Reset asserted mid-frame (LOAD, SOLVE or EMIT) SHALL discard the partial frame; the buffer contents need not be cleared.

Configuration
REQ-020 With macro RS_DEC_ERR_COUNT_EN defined: add outputs corr_count and uncorr_count, each 16 bits.
  - Each counter increments once per frame on entry to EMIT when the matching flag is set.
  - Counters saturate at 16'hFFFF and reset to 0.
REQ-021 Without RS_DEC_ERR_COUNT_EN: neither port nor any counter logic SHALL exist.

Structure
REQ-022 Package rs_pkg SHALL hold the FSM state typedef, the N/K derivation function and the GF multiply function.
REQ-023 Sub-module rs_gf_log SHALL provide the log/antilog tables for a given SYMBOL_WIDTH/PRIM_POLY; it is used by the SOLVE divider and for the position lookup.

Verification (SYMBOL_WIDTH=3, PRIM_POLY=4'b1011, N=7)
REQ-024 All-zero frame (7 symbols) -> 3 SOLVE cycles, then 7 outputs of 0; out_corrected=0, out_uncorrectable=0, out_last on the 7th output.
REQ-025 All-zero frame with r[2]=3 -> output r[2]=0, all other outputs 0, out_corrected=1.
REQ-026 All-zero frame with r[0]=2 and r[1]=1 (S1=0, S2!=0) -> outputs identical to input, out_uncorrectable=1.
REQ-027 Error r[6]=5 with out_ready toggling 1,0,0,1 during EMIT -> no symbol lost or duplicated; out_symbol stable while stalled; r[6] corrected to 0.
REQ-028 Reset=0 after 4 LOAD beats, then a full clean frame -> the clean frame is decoded correctly with no corruption from the discarded partial frame.
REQ-029 With RS_DEC_ERR_COUNT_EN: 3 corrected frames + 1 uncorrectable frame -> corr_count=3, uncorr_count=1.
